regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the RISC datapath, the successor to the 8x16 dual-read file.
- Provides NUM_RD combinational read ports and one synchronous write port.
- Dedicates the top register as the PC, with its own update port.
- Tracks pending writes with a per-register busy scoreboard, so decode can detect RAW hazards without external bookkeeping.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 8, number of registers (power of two, >=2)
ADDR_W, 3, register address width, equal to log2(NUM_REGS)
NUM_RD, 2, number of read ports (1..4)
PC_IDX, NUM_REGS-1, index of the register used as the program counter

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write enable for the writeback port
wr_addr  in  ADDR_W  writeback register index
wr_data  in  DATA_W  writeback data
rd_addr  in  NUM_RD*ADDR_W  read indices; port i occupies bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
rd_ready  out  NUM_RD  port i data is valid, i.e. no write is pending on that register
rsv_en  in  1  reserve a destination register at issue
rsv_addr  in  ADDR_W  index of the register to reserve
pc_we  in  1  PC update enable (sequential fetch)
pc_in  in  DATA_W  next PC value
pc_out  out  DATA_W  current contents of register PC_IDX
busy  out  NUM_REGS  scoreboard vector; bit r is set while register r has a write pending
sb_err  out  1  sticky scoreboard error flag

Behaviour:
- Reset (clk edge with reset=1):
  - all registers, busy and sb_err clear to 0.
  - Consequently rd_data=0, rd_ready all 1, pc_out=0 in the cycle after reset.
  - Reset overrides every other input in that cycle.
- Write port:
  - wr_en=1 loads wr_data into reg[wr_addr] at the clock edge.
  - The new value is visible to reads on the next cycle, except where the optional bypass applies.
- PC port:
  - pc_we=1 loads pc_in into reg[PC_IDX].
  - If wr_en=1 with wr_addr=PC_IDX in the same cycle, wr_data wins (branch or jump writeback overrides sequential fetch) and pc_in is dropped.
- Read ports:
  - Purely combinational: rd_data[i] = reg[rd_addr[i]]; zero latency.
  - All ports are independent and may address the same register.
- Scoreboard, per register r:
  - Next state is busy[r] <= (busy[r] & ~clr_r) | set_r.
  - set_r = rsv_en & (rsv_addr==r).
  - clr_r = wr_en & (wr_addr==r).
  - When a set and a clear hit the same register in the same cycle, set wins and busy stays 1: the old write retires while a new one is issued.
  - pc_we does not touch the scoreboard.
- rd_ready[i] = ~busy[rd_addr[i]], subject to the bypass override below.
- Error flag:
  - sb_err sets on rsv_en=1 to a register that is already busy and is not being cleared in the same cycle (double reservation).
  - sb_err also sets on wr_en=1 to a register that is not busy and is not PC_IDX (unexpected writeback).
  - sb_err stays set until reset. Functional state updates proceed normally in both cases.
- Out-of-range addresses cannot occur because NUM_REGS is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding. For each port i, if wr_en=1 and wr_addr==rd_addr[i], rd_data[i]=wr_data and rd_ready[i]=1 in the same cycle.
  - If instead pc_we=1, rd_addr[i]==PC_IDX, and there is no same-cycle wr_en to PC_IDX, rd_data[i]=pc_in.
- Undefined:
  - Reads return stored contents only. The same-cycle written value appears on the next cycle, and rd_ready follows busy strictly.

Test Plan:
1. Reset with 0xFFFF driven on every input, then release -> rd_data=0, busy=0, rd_ready=all 1, sb_err=0, pc_out=0.
2. Write reg3=0x1234 and reg5=0xABCD on consecutive cycles, then read with rd_addr={3,5} -> rd_data={0x1234,0xABCD}; both ports reading reg3 -> both return 0x1234.
3. Reserve reg2, read reg2 -> rd_ready=0, busy=0x04. Then wr_en reg2=0x0042 -> next cycle busy=0, rd_ready=1, data 0x0042. Repeat with a same-cycle reserve and write of reg2 -> busy[2] stays 1.
4. pc_we=1 with pc_in=0x0010 together with wr_en to reg7 = 0x0200 -> pc_out=0x0200. Next cycle pc_we alone with pc_in=0x0202 -> pc_out=0x0202; busy unchanged.
5. Reserve reg4 twice in a row -> sb_err=1, held through 10 idle cycles, cleared only by reset. Write reg1 while not busy -> sb_err=1.
6. With REGFILE_BYPASS_EN, wr_en reg6=0x5555 while rd_addr[0]=6 -> same-cycle rd_data[0]=0x5555, rd_ready[0]=1. Without the macro -> old value that cycle, 0x5555 the next.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: parametrised register file with NUM_RD combinational read
// ports, one synchronous writeback port, a dedicated PC register (PC_IDX)
// with its own update port, and a per-register busy scoreboard with a sticky
// error flag for double reservations and unexpected writebacks.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through
// forwarding of wr_data / pc_in onto the read ports.
module regfile_mp_sb #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int NUM_RD   = 2,
   parameter int PC_IDX   = NUM_REGS - 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_ready,
   input  logic                       rsv_en,
   input  logic [ADDR_W-1:0]          rsv_addr,
   input  logic                       pc_we,
   input  logic [DATA_W-1:0]          pc_in,
   output logic [DATA_W-1:0]          pc_out,
   output logic [NUM_REGS-1:0]        busy,
   output logic                       sb_err
);

   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] clr_vec;
   logic                pc_wr_hit;
   logic                err_double;
   logic                err_unexp;

   // Decode reservation / writeback into per-register set and clear strobes.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      set_vec = '0;
      clr_vec = '0;
      if (rsv_en) set_vec[rsv_addr] = 1'b1;
      if (wr_en)  clr_vec[wr_addr]  = 1'b1;
   end

   // A writeback to the PC register takes priority over sequential fetch.
   assign pc_wr_hit  = wr_en && (wr_addr == PC_ADDR);

   // Double reservation: reserving a busy register that is not retiring now.
   assign err_double = rsv_en && busy[rsv_addr] && !clr_vec[rsv_addr];

   // Unexpected writeback: writing a non-PC register with nothing pending.
   assign err_unexp  = wr_en && !busy[wr_addr] && (wr_addr != PC_ADDR);

   // Register array, scoreboard and sticky error flag update.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side sees the pre-edge value regardless of statement order.
      if (reset) begin
         // NOTE: the array is cleared on reset because reads must return
         // zero right after reset; this costs a reset net per storage bit.
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
         busy   <= '0;
         sb_err <= 1'b0;
      end else begin
         if (wr_en) regs[wr_addr] <= wr_data;
         if (pc_we && !pc_wr_hit) regs[PC_ADDR] <= pc_in;
         // Set wins over clear: an old write retires while a new one issues.
         busy   <= (busy & ~clr_vec) | set_vec;
         sb_err <= sb_err | err_double | err_unexp;
      end
   end

   assign pc_out = regs[PC_ADDR];

   // Independent read ports; each may address any register.
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] data;
      logic              rdy;

      assign ra = rd_addr[i*ADDR_W +: ADDR_W];

      // Select stored contents, optionally overridden by same-cycle writes.
      always_comb begin
         data = regs[ra];
         rdy  = ~busy[ra];
`ifdef REGFILE_BYPASS_EN
         if (wr_en && (wr_addr == ra)) begin
            data = wr_data;
            rdy  = 1'b1;
         end else if (pc_we && (ra == PC_ADDR)) begin
            // Reached only without a same-cycle writeback to the PC.
            data = pc_in;
         end
`endif
      end

      assign rd_data[i*DATA_W +: DATA_W] = data;
      assign rd_ready[i]                 = rdy;
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed self-checking bench for regfile_mp_sb with the
// default parameters (8 x 16-bit, 2 read ports, PC at register 7).
// Expected values are hand-computed; the same-cycle read expectations
// follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_mp_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  rd_ready;
   logic        rsv_en;
   logic [2:0]  rsv_addr;
   logic        pc_we;
   logic [15:0] pc_in;
   logic [15:0] pc_out;
   logic [7:0]  busy;
   logic        sb_err;

   int tests = 0;
   int fails = 0;

   regfile_mp_sb dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_ready (rd_ready),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .pc_we    (pc_we),
      .pc_in    (pc_in),
      .pc_out   (pc_out),
      .busy     (busy),
      .sb_err   (sb_err)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset    = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
      pc_we    = 1'b0;
      pc_in    = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Safety net in case the run never reaches its summary.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. Reset with every input driven high; reset must override all of it.
      reset    = 1'b1;
      wr_en    = 1'b1;
      wr_addr  = '1;
      wr_data  = '1;
      rd_addr  = '1;
      rsv_en   = 1'b1;
      rsv_addr = '1;
      pc_we    = 1'b1;
      pc_in    = '1;
      tick();
      tick();
      idle();
      rd_addr = {3'd7, 3'd0};
      #1;
      check("rst_rd_data",  rd_data,  32'h0);
      check("rst_busy",     busy,     8'h00);
      check("rst_rd_ready", rd_ready, 2'b11);
      check("rst_sb_err",   sb_err,   1'b0);
      check("rst_pc_out",   pc_out,   16'h0);

      // 2. Reserve reg3/reg5, then write them back on consecutive cycles.
      rsv_en = 1'b1; rsv_addr = 3'd3;
      tick();
      rsv_addr = 3'd5;
      tick();
      rsv_en = 1'b0;
      check("rsv35_busy", busy, 8'h28);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
      tick();
      wr_addr = 3'd5; wr_data = 16'hABCD;
      tick();
      idle();
      rd_addr = {3'd5, 3'd3};
      #1;
      check("rd_35",        rd_data,  32'hABCD_1234);
      check("wr35_busy",    busy,     8'h00);
      check("wr35_ready",   rd_ready, 2'b11);
      check("wr35_sb_err",  sb_err,   1'b0);
      rd_addr = {3'd3, 3'd3};
      #1;
      check("rd_33",        rd_data,  32'h1234_1234);

      // 3. Scoreboard: reserve reg2, write it back, then same-cycle set+clear.
      rsv_en = 1'b1; rsv_addr = 3'd2;
      tick();
      rsv_en = 1'b0;
      rd_addr = {3'd3, 3'd2};
      #1;
      check("rsv2_busy",    busy,     8'h04);
      check("rsv2_ready",   rd_ready, 2'b10);
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0042;
      tick();
      idle();
      #1;
      check("wb2_busy",     busy,         8'h00);
      check("wb2_ready",    rd_ready,     2'b11);
      check("wb2_data",     rd_data[15:0], 16'h0042);
      rsv_en = 1'b1; rsv_addr = 3'd2;
      tick();
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0043;
      tick();
      idle();
      #1;
      check("setclr2_busy",   busy,          8'h04);
      check("setclr2_sb_err", sb_err,        1'b0);
      check("setclr2_data",   rd_data[15:0], 16'h0043);
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0044;
      tick();
      idle();
      #1;
      check("retire2_busy",   busy, 8'h00);

      // 4. PC port: writeback beats sequential fetch; pc_we leaves busy alone.
      pc_we = 1'b1; pc_in = 16'h0010;
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h0200;
      tick();
      idle();
      #1;
      check("pc_wb_wins",   pc_out, 16'h0200);
      check("pc_wb_sb_err", sb_err, 1'b0);
      pc_we = 1'b1; pc_in = 16'h0202;
      tick();
      idle();
      #1;
      check("pc_seq",       pc_out, 16'h0202);
      check("pc_seq_busy",  busy,   8'h00);
      rsv_en = 1'b1; rsv_addr = 3'd7;
      tick();
      idle();
      pc_we = 1'b1; pc_in = 16'h0204;
      tick();
      idle();
      #1;
      check("pc_rsv_busy",  busy,   8'h80);
      check("pc_rsv_pc",    pc_out, 16'h0204);
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h0300;
      tick();
      idle();
      rd_addr = {3'd7, 3'd3};
      #1;
      check("pc_jmp_busy",  busy,           8'h00);
      check("pc_jmp_rd",    rd_data[31:16], 16'h0300);
      check("pc_jmp_err",   sb_err,         1'b0);

      // 5. Sticky error: double reservation, then unexpected writeback.
      rsv_en = 1'b1; rsv_addr = 3'd4;
      tick();
      #1;
      check("rsv4_once_err", sb_err, 1'b0);
      tick();
      idle();
      #1;
      check("rsv4_twice_err", sb_err, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      check("err_sticky", sb_err, 1'b1);
      do_reset();
      rd_addr = {3'd5, 3'd3};
      #1;
      check("err_cleared",  sb_err,  1'b0);
      check("rst2_busy",    busy,    8'h00);
      check("rst2_rd_data", rd_data, 32'h0);
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0001;
      tick();
      idle();
      #1;
      check("unexp_wb_err", sb_err, 1'b1);
      do_reset();

      // 6. Same-cycle read of a register being written.
      rsv_en = 1'b1; rsv_addr = 3'd6;
      tick();
      idle();
      wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h5555;
      rd_addr = {3'd3, 3'd6};
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_data",  rd_data[15:0], 16'h5555);
      check("byp_ready", rd_ready[0],   1'b1);
`else
      check("nobyp_data",  rd_data[15:0], 16'h0000);
      check("nobyp_ready", rd_ready[0],   1'b0);
`endif
      tick();
      idle();
      #1;
      check("wr6_next_data",  rd_data[15:0], 16'h5555);
      check("wr6_next_ready", rd_ready[0],   1'b1);
      pc_we = 1'b1; pc_in = 16'h0777;
      rd_addr = {3'd7, 3'd6};
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_pc", rd_data[31:16], 16'h0777);
`else
      check("nobyp_pc", rd_data[31:16], 16'h0000);
`endif
      tick();
      idle();
      #1;
      check("pc_next", rd_data[31:16], 16'h0777);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
